inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Fetch stage directly upstream of the decode stage. Sequences the program counter into
//   instmem and buffers {pc, inst} pairs in a small FIFO. Redirects from the branch/jump
//   logic flush the buffer and restart fetch at a new word-aligned PC.
//   Handshake to decode is valid/ready.
// PARAMETERS
//   W         32       word length (`WORD_LEN)
//   DEPTH     4        FIFO entries, power of two, >= 2
//   RESET_PC  32'h0    first fetch address after reset
// PORTS
//   clk             in   1   rising-edge clock
//   rst             in   1   synchronous active-high reset
//   imem_addr       out  W   fetch address to instmem Addr
//   imem_inst       in   W   instmem Inst; combinational response to imem_addr, same cycle
//   redirect_valid  in   1   flush FIFO and restart fetch
//   redirect_pc     in   W   new fetch PC; bits [1:0] ignored (forced 0)
//   out_valid       out  1   head entry available to decode
//   out_ready       in   1   decode accepts head entry
//   out_pc          out  W   PC of head entry
//   out_inst        out  W   instruction of head entry
// BEHAVIOUR
//   State
//   - fetch_pc (W bits), DEPTH x {pc, inst} storage, rd_ptr and wr_ptr (log2(DEPTH) bits),
//     count (log2(DEPTH)+1 bits).
//   - Reset (sync, highest priority): fetch_pc=RESET_PC, pointers=0, count=0.
//     Outputs then read out_valid=0, out_pc=0, out_inst=0.
//   Outputs
//   - imem_addr = fetch_pc, driven straight from the register.
//   - out_valid = (count!=0) & ~redirect_valid.
//   - out_pc/out_inst = head entry when count!=0; 0 otherwise.
//   Events per cycle
//   - pop  = out_valid & out_ready
//   - push = ~redirect_valid & (count<DEPTH | pop)
//   Normal cycle (no redirect)
//   - push: write {fetch_pc, imem_inst} at wr_ptr; wr_ptr+=1 (wraps mod DEPTH);
//     fetch_pc+=4 (wraps mod 2^W).
//   - pop: rd_ptr+=1 (wraps mod DEPTH).
//   - count += push - pop; push and pop together leave count unchanged.
//   - Full with no pop: no push, fetch_pc holds, imem_addr stable.
//   Redirect cycle
//   - No push and no pop (out_valid is 0).
//   - Next cycle: count=0, rd_ptr=wr_ptr=0, fetch_pc={redirect_pc[W-1:2],2'b00}.
//   - Back-to-back redirects: the last one wins.
//   - Redirect while full or while empty: same result.
//   Latency and throughput
//   - An instruction fetched in cycle N is visible on out_* in cycle N+1.
//   - Sustained throughput is 1 instruction/cycle while out_ready=1.
//   Reset mid-operation
//   - Overrides redirect and push; all buffered entries are discarded.
//   Invariants
//   - count never exceeds DEPTH and never underflows.
//   - Entries pop in push order with PCs strictly +4 apart between redirects.
// TESTING
//   1. Reset, RESET_PC=0, out_ready=1, mem[i]=i+100
//      -> imem_addr 0,4,8,... one per cycle; out_pc=0/out_inst=100 from cycle 1;
//         one entry per cycle thereafter.
//   2. out_ready=0 for 10 cycles after reset
//      -> exactly 4 pushes; count=4; imem_addr held at 16.
//      Then out_ready=1 -> out_pc 0,4,8,12,16,... with no gaps or duplicates.
//   3. Full FIFO, out_ready=1 for one cycle
//      -> pop and push in the same cycle; count stays 4; fetch_pc 16->20.
//   4. FIFO holding 3 entries, redirect_valid=1, redirect_pc=32'h0000_0043
//      -> out_valid=0 that cycle; next cycle imem_addr=32'h40, count=0;
//         following cycle out_pc=32'h40.
//   5. RESET_PC=32'hFFFF_FFF8, out_ready=1
//      -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
//   6. rst asserted in the same cycle as redirect_valid, with 2 entries queued
//      -> next cycle fetch_pc=RESET_PC, count=0, out_valid=0; redirect ignored.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Fetch stage: walks the PC through instmem and buffers {pc, inst} pairs for decode.
// A redirect flushes the buffer and restarts fetch at a word-aligned PC.
module inst_fetch_queue #(
  parameter int unsigned    W        = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [W-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] imem_addr,
  input  logic [W-1:0] imem_inst,
  input  logic         redirect_valid,
  input  logic [W-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pc,
  output logic [W-1:0] out_inst
);

  localparam int unsigned   AW        = $clog2(DEPTH);
  localparam logic [AW:0]   CountFull = (AW+1)'(DEPTH);

  logic [W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [W-1:0]  pc_mem_q   [DEPTH];
  logic [W-1:0]  inst_mem_q [DEPTH];

  logic not_empty;
  logic pop;
  logic push;

  // A redirect hides the head so decode never consumes a soon-to-be-flushed entry.
  always_comb begin
    not_empty = (count_q != '0);
    out_valid = not_empty & ~redirect_valid;
    pop       = out_valid & out_ready;
    push      = ~redirect_valid & ((count_q < CountFull) | pop);
    imem_addr = fetch_pc_q;
    out_pc    = not_empty ? pc_mem_q[rd_ptr_q]   : '0;
    out_inst  = not_empty ? inst_mem_q[rd_ptr_q] : '0;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[W-1:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count is nonzero.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
      inst_mem_q[wr_ptr_q] <= imem_inst;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic against a queue model.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic [31:0] imem_addr, imem_inst, out_pc, out_inst;
  logic        out_valid;
  logic [31:0] imem_addr2, imem_inst2, out_pc2, out_inst2;
  logic        out_valid2;

  int total = 0;
  int bad   = 0;
  int since_rst = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  assign imem_inst  = memfn(imem_addr);
  assign imem_inst2 = memfn(imem_addr2);

  inst_fetch_queue #(.W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  inst_fetch_queue #(.W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_inst(imem_inst2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid2), .out_ready(1'b1), .out_pc(out_pc2), .out_inst(out_inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check outputs, then advance the model.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
    logic        e_valid;
    logic [31:0] e_pc, e_inst, e2;
    logic        do_pop, do_push;
    @(negedge clk);
    rst = r;
    redirect_valid = rv;
    redirect_pc = rp;
    out_ready = rdy;
    #1;
    e_valid = (mq.size() != 0) && !rv;
    e_pc    = (mq.size() != 0) ? mq[0].pc : 32'h0;
    e_inst  = (mq.size() != 0) ? mq[0].inst : 32'h0;
    check("imem_addr", imem_addr, m_pc);
    check("out_valid", {31'h0, out_valid}, {31'h0, e_valid});
    check("out_pc", out_pc, e_pc);
    check("out_inst", out_inst, e_inst);
    if (since_rst < 6) begin
      e2 = 32'hFFFF_FFF8 + 32'(4 * since_rst);
      check("wrap_addr", imem_addr2, e2);
      check("wrap_valid", {31'h0, out_valid2}, (since_rst > 0) ? 32'h1 : 32'h0);
      if (since_rst > 0) begin
        check("wrap_pc", out_pc2, e2 - 32'd4);
        check("wrap_inst", out_inst2, memfn(e2 - 32'd4));
      end
    end
    if (r) begin
      mq.delete();
      m_pc = 32'h0;
      since_rst = 0;
    end else begin
      since_rst++;
      if (rv) begin
        mq.delete();
        m_pc = {rp[31:2], 2'b00};
      end else begin
        do_pop  = e_valid && rdy;
        do_push = (mq.size() < 4) || do_pop;
        if (do_pop) void'(mq.pop_front());
        if (do_push) begin
          mq.push_back('{pc: m_pc, inst: memfn(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    mq.delete();
    m_pc = 32'h0;
    since_rst = 0;

    // Streaming at one per cycle from reset.
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Stall fills the queue, then a pop and push in the same cycle.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t2_hold_addr", imem_addr, 32'd16);
    check("t3_head_pc", out_pc, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t3_addr_adv", imem_addr, 32'd20);
    check("t3_next_pc", out_pc, 32'd4);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Redirect with three entries queued.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0043, 1'b1);
    check("t4_valid_low", {31'h0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_addr", imem_addr, 32'h40);
    check("t4_empty", {31'h0, out_valid}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("t4_pc", out_pc, 32'h40);
    check("t4_inst", out_inst, 32'd116);

    // Back-to-back redirects: last wins.
    step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0302, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("b2b_addr", imem_addr, 32'h300);

    // Reset coincident with redirect, two entries queued.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    check("t6_addr", imem_addr, 32'h0);
    check("t6_valid", {31'h0, out_valid}, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0), $urandom,
           ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
